// File: rtl/mdr_mem_if.sv
// Memory data register with its own req/ack memory port: bus loads, byte/halfword/full
// reads and writes with lane steering, sign/zero extension, alignment check and ack timeout.
module mdr_mem_if #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  localparam int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     BusMuxOut,
  input  logic                  mdr_in,
  input  logic                  rd_start,
  input  logic                  wr_start,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [OFF_W-1:0]      byte_off,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack,
  output logic [DATA_W-1:0]     Q,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int NB = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t            state, state_next;
  logic [1:0]        size_lat, size_lat_next;
  logic              sext_lat, sext_lat_next;
  logic [OFF_W-1:0]  off_lat, off_lat_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [DATA_W-1:0] q_next, wdata_next;
  logic [NB-1:0]     be_next;
  logic              req_next, we_next, busy_next, done_next, err_next;

  logic [DATA_W-1:0] byte_rep, half_rep, rd_shift, rd_ext;

  // Write data: the low byte / halfword of Q copied into every lane it can occupy.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign byte_rep[gi*8 +: 8] = Q[7:0];
      assign half_rep[gi*8 +: 8] = Q[(gi%2)*8 +: 8];
    end
  endgenerate

  function automatic logic misaligned(input logic [1:0] sz, input logic [OFF_W-1:0] off);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return |off;
    endcase
  endfunction

  function automatic logic [NB-1:0] lane_mask(input logic [1:0] sz, input logic [OFF_W-1:0] off);
    case (sz)
      2'b00:   return NB'(1) << off;
      2'b01:   return NB'(3) << off;
      default: return '1;
    endcase
  endfunction

  // Read path uses the attributes latched at start, not the live inputs.
  assign rd_shift = mem_rdata >> {off_lat, 3'b000};

  always_comb begin
    case (size_lat)
      2'b00:   rd_ext = {{(DATA_W-8){sext_lat & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   rd_ext = {{(DATA_W-16){sext_lat & rd_shift[15]}}, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  always_comb begin
    state_next    = state;
    size_lat_next = size_lat;
    sext_lat_next = sext_lat;
    off_lat_next  = off_lat;
    cnt_next      = cnt;
    q_next        = Q;
    req_next      = mem_req;
    we_next       = mem_we;
    wdata_next    = mem_wdata;
    be_next       = mem_be;
    busy_next     = busy;
    done_next     = 1'b0;
    err_next      = 1'b0;

    case (state)
      IDLE: begin
        if (rd_start || wr_start) begin
          if (misaligned(size, byte_off)) begin
            err_next = 1'b1;
          end else begin
            req_next  = 1'b1;
            busy_next = 1'b1;
            cnt_next  = '0;
            be_next   = lane_mask(size, byte_off);
            if (rd_start) begin
              we_next       = 1'b0;
              size_lat_next = size;
              sext_lat_next = sign_ext;
              off_lat_next  = byte_off;
              state_next    = RD;
            end else begin
              we_next = 1'b1;
              case (size)
                2'b00:   wdata_next = byte_rep;
                2'b01:   wdata_next = half_rep;
                default: wdata_next = Q;
              endcase
              state_next = WR;
            end
          end
        end else if (mdr_in) begin
          q_next = BusMuxOut;
        end
      end

      RD, WR: begin
        if (mem_ack) begin
          done_next  = 1'b1;
          req_next   = 1'b0;
          busy_next  = 1'b0;
          state_next = IDLE;
          if (state == RD) q_next = rd_ext;
        end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
          err_next   = 1'b1;
          req_next   = 1'b0;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else if (TIMEOUT != 0) begin
          cnt_next = cnt + 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      size_lat  <= '0;
      sext_lat  <= 1'b0;
      off_lat   <= '0;
      cnt       <= '0;
      Q         <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      mem_be    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_next;
      size_lat  <= size_lat_next;
      sext_lat  <= sext_lat_next;
      off_lat   <= off_lat_next;
      cnt       <= cnt_next;
      Q         <= q_next;
      mem_req   <= req_next;
      mem_we    <= we_next;
      mem_wdata <= wdata_next;
      mem_be    <= be_next;
      busy      <= busy_next;
      done      <= done_next;
      err       <= err_next;
    end
  end

endmodule

// File: tb/tb_mdr_mem_if.sv
// Randomised scoreboard bench for mdr_mem_if: expected done/err responses are queued at
// issue time and a negedge monitor pops and checks them against a byte-level model.
module tb_mdr_mem_if;
  localparam int DW = 32;
  localparam int NB = DW / 8;
  localparam int TO = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] BusMuxOut;
  logic          mdr_in, rd_start, wr_start;
  logic [1:0]    size;
  logic          sign_ext;
  logic [1:0]    byte_off;
  logic          mem_req, mem_we;
  logic [DW-1:0] mem_wdata;
  logic [NB-1:0] mem_be;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic [DW-1:0] Q;
  logic          busy, done, err;

  mdr_mem_if #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .BusMuxOut(BusMuxOut), .mdr_in(mdr_in),
    .rd_start(rd_start), .wr_start(wr_start), .size(size), .sign_ext(sign_ext),
    .byte_off(byte_off), .mem_req(mem_req), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .Q(Q), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit            is_err;
    logic [DW-1:0] q;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [DW-1:0] q_model;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model (byte lanes, plain arithmetic) ----------------
  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : NB;
  endfunction

  function automatic bit is_aligned(input logic [1:0] s, input logic [1:0] off);
    return (int'(off) % nbytes(s)) == 0;
  endfunction

  function automatic logic [NB-1:0] model_lanes(input logic [1:0] s, input logic [1:0] off);
    logic [NB-1:0] m = '0;
    for (int i = 0; i < NB; i++)
      if (i >= int'(off) && i < int'(off) + nbytes(s)) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [DW-1:0] rd, input logic [1:0] s,
                                               input bit sx, input logic [1:0] off);
    logic [63:0] v = 0;
    int n = nbytes(s);
    for (int k = 0; k < n; k++) v = v | (64'((rd >> (8 * (int'(off) + k))) & 8'hFF) << (8 * k));
    if (sx && ((v >> (8 * n - 1)) & 64'd1) == 64'd1) v = v - (64'd1 << (8 * n));
    return v[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] model_wdata(input logic [DW-1:0] q, input logic [1:0] s);
    logic [DW-1:0] w = '0;
    int n = nbytes(s);
    for (int i = 0; i < NB; i++) w = w | (DW'((q >> (8 * (i % n))) & 8'hFF) << (8 * i));
    return w;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (!reset && (done || err)) begin
      check("done_err_exclusive", 64'(done & err), 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_response: done=%0b err=%0b with nothing pending (t=%0t)", done, err, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_is_err", 64'(err), 64'(mon_e.is_err));
        check("resp_q", 64'(Q), 64'(mon_e.q));
        $display("resp: %s Q=%08h expected %08h", err ? "err " : "done", Q, mon_e.q);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_inputs();
    mdr_in = 1'b0; rd_start = 1'b0; wr_start = 1'b0;
  endtask

  task automatic do_load(input logic [DW-1:0] val);
    @(negedge clock);
    BusMuxOut = val; mdr_in = 1'b1;
    @(negedge clock);
    mdr_in = 1'b0;
    q_model = val;
    check("load_q", 64'(Q), 64'(val));
    check("load_busy", 64'(busy), 64'd0);
    check("load_req", 64'(mem_req), 64'd0);
    $display("load: Q=%08h", Q);
  endtask

  // delay = wait cycles before ack; delay >= TO means no ack (timeout).
  task automatic do_access(input bit wr, input logic [1:0] s, input bit sx, input logic [1:0] off,
                           input logic [DW-1:0] rdata, input int delay, input bit also_mdr);
    bit ok = is_aligned(s, off);
    bit timeout = (delay >= TO);
    logic [DW-1:0] exp_wd = model_wdata(q_model, s);
    int req_cycles;
    exp_t e;
    if (!ok || (timeout)) e = '{is_err: 1'b1, q: q_model};
    else if (wr) e = '{is_err: 1'b0, q: q_model};
    else e = '{is_err: 1'b0, q: model_read(rdata, s, sx, off)};
    exp_q.push_back(e);
    q_model = e.q;

    @(negedge clock);
    rd_start = !wr; wr_start = wr; size = s; sign_ext = sx; byte_off = off;
    mdr_in = also_mdr; BusMuxOut = $urandom;
    @(negedge clock);
    clear_inputs();
    $display("access: %s size=%0d off=%0d sx=%0b delay=%0d mdr_in=%0b", wr ? "WR" : "RD", s, off, sx, delay, also_mdr);
    if (!ok) begin
      check("misalign_no_req", 64'(mem_req), 64'd0);
      check("misalign_not_busy", 64'(busy), 64'd0);
      return;
    end
    check("req_asserted", 64'(mem_req), 64'd1);
    check("busy_asserted", 64'(busy), 64'd1);
    check("req_we", 64'(mem_we), 64'(wr));
    check("req_be", 64'(mem_be), 64'(model_lanes(s, off)));
    if (wr) check("req_wdata", 64'(mem_wdata), 64'(exp_wd));
    req_cycles = 1;
    for (int w = 0; w < delay && w < 64; w++) begin
      // inputs poked while busy must all be ignored
      mdr_in = 1'($urandom); wr_start = 1'($urandom); rd_start = 1'($urandom);
      BusMuxOut = $urandom; size = 2'($urandom); byte_off = 2'($urandom); sign_ext = 1'($urandom);
      mem_rdata = $urandom;
      @(negedge clock);
      clear_inputs();
      if (!mem_req) break;
      req_cycles++;
    end
    if (timeout) begin
      check("timeout_req_cycles", 64'(req_cycles), 64'(TO));
      check("timeout_req_low", 64'(mem_req), 64'd0);
    end else begin
      if (wr) check("wdata_held", 64'(mem_wdata), 64'(exp_wd));
      mem_ack = 1'b1; mem_rdata = rdata;
      @(negedge clock);
      mem_ack = 1'b0; mem_rdata = $urandom;
      check("ack_req_cycles", 64'(req_cycles), 64'(delay + 1));
      check("ack_req_low", 64'(mem_req), 64'd0);
      check("ack_busy_low", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit wr, sx, md;
    logic [1:0] s, off;
    int r, d;
    reset = 1'b1; clear_inputs();
    BusMuxOut = '0; size = '0; sign_ext = 1'b0; byte_off = '0; mem_rdata = '0; mem_ack = 1'b0;
    q_model = '0;
    #1;
    check("rst_q", 64'(Q), 64'd0);
    check("rst_req", 64'(mem_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done_err", 64'({done, err, mem_we}), 64'd0);
    check("rst_be_wdata", 64'({mem_be, mem_wdata}), 64'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;

    // directed cases
    do_load(32'h1234_5678);
    do_access(1'b0, 2'b00, 1'b1, 2'd3, 32'h80F0_1234, 0, 1'b0);
    check("tp_signed_byte", 64'(Q), 64'h0000_0000_FFFF_FF80);
    do_access(1'b0, 2'b00, 1'b0, 2'd3, 32'h80F0_1234, 0, 1'b0);
    check("tp_unsigned_byte", 64'(Q), 64'h0000_0080);
    do_access(1'b0, 2'b01, 1'b0, 2'd2, 32'h80F0_1234, 3, 1'b0);
    check("tp_half_read", 64'(Q), 64'h0000_80F0);
    do_load(32'h0000_00AB);
    do_access(1'b1, 2'b00, 1'b0, 2'd1, '0, 1, 1'b0);
    check("tp_byte_wdata", 64'(mem_wdata), 64'hABAB_ABAB);
    check("tp_byte_be", 64'(mem_be), 64'b0010);
    check("tp_write_q", 64'(Q), 64'h0000_00AB);
    do_access(1'b0, 2'b01, 1'b0, 2'd1, 32'hDEAD_BEEF, 0, 1'b0);
    do_access(1'b0, 2'b10, 1'b0, 2'd0, 32'hDEAD_BEEF, 100, 1'b0);
    check("tp_timeout_q", 64'(Q), 64'h0000_00AB);
    do_access(1'b0, 2'b10, 1'b0, 2'd0, 32'hCAFE_F00D, TO - 1, 1'b0);
    do_access(1'b0, 2'b11, 1'b0, 2'd0, 32'h1357_9BDF, 0, 1'b1);
    check("tp_rd_beats_mdr_in", 64'(Q), 64'h1357_9BDF);
    repeat (2) @(negedge clock);

    // reset in the middle of a read
    rd_start = 1'b1; size = 2'b10; byte_off = 2'd0;
    @(negedge clock);
    rd_start = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("midrd_rst_req", 64'(mem_req), 64'd0);
    check("midrd_rst_busy", 64'(busy), 64'd0);
    check("midrd_rst_q", 64'(Q), 64'd0);
    $display("reset mid-read: mem_req=%0b busy=%0b Q=%08h", mem_req, busy, Q);
    q_model = '0;
    @(negedge clock);
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clock);
    mem_ack = 1'b0;
    @(negedge clock);
    check("idle_ack_ignored_q", 64'(Q), 64'd0);
    check("idle_ack_ignored_req", 64'(mem_req), 64'd0);

    // randomised traffic
    for (int t = 0; t < 200; t++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        do_load($urandom);
      end else begin
        wr = 1'($urandom); sx = 1'($urandom); s = 2'($urandom); md = ($urandom_range(0, 3) == 0);
        off = 2'($urandom);
        if ($urandom_range(0, 9) < 7) off = 2'(int'(off) / nbytes(s) * nbytes(s));
        r = $urandom_range(0, 19);
        if (r < 13) d = $urandom_range(0, 4);
        else if (r < 15) d = TO - 1;
        else if (r < 16) d = 100;
        else d = $urandom_range(5, 14);
        do_access(wr, s, sx, off, $urandom, d, md);
      end
    end

    repeat (3) @(negedge clock);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdr_mem_if.md
Name: mdr_mem_if

Overview:
Parametrised memory data register with its own memory-side handshake. Loads from the internal bus, or runs byte/halfword/full-width reads and writes against a req/ack memory port with lane steering, sign/zero extension, alignment checking and an ack timeout. Sits between the datapath bus mux and the memory controller, and replaces the fixed 32-bit bus/memory-select MDR.

Parameters:
DATA_W, 32, register and memory data width; multiple of 32, 32 or 64 supported.
TIMEOUT, 16, cycles to wait for mem_ack before aborting; 0 disables the timeout.
OFF_W, log2(DATA_W/8), byte-offset width (derived, not overridden).

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
BusMuxOut  in  DATA_W  internal bus value
mdr_in  in  1  load Q from BusMuxOut
rd_start  in  1  start memory read (1-cycle pulse)
wr_start  in  1  start memory write (1-cycle pulse)
size  in  2  00 byte, 01 halfword, 10/11 full width
sign_ext  in  1  read: 1 sign-extend, 0 zero-extend
byte_off  in  OFF_W  byte offset of access within the memory word
mem_req  out  1  memory request, held until ack or abort
mem_we  out  1  1 write, 0 read; valid while mem_req
mem_wdata  out  DATA_W  write data
mem_be  out  DATA_W/8  byte enables
mem_rdata  in  DATA_W  read data, valid with mem_ack
mem_ack  in  1  memory completion
Q  out  DATA_W  register contents
busy  out  1  transaction in flight
done  out  1  1-cycle pulse on successful completion
err  out  1  1-cycle pulse on misalignment or timeout

Behaviour:
- Reset (async): Q=0; mem_req=0; mem_we=0; mem_wdata=0; mem_be=0; busy=0; done=0; err=0; state=IDLE; timeout count=0. Reset mid-transaction drops mem_req immediately, and the transaction is lost.
- All outputs are registered. States: IDLE, RD, WR.
- IDLE priority: rd_start > wr_start > mdr_in. Any start in the same cycle as mdr_in causes mdr_in to be ignored. mdr_in alone: Q <= BusMuxOut at the edge.
- Alignment: a halfword needs byte_off[0]=0; a full-width access needs byte_off=0. A misaligned start gives err=1 on the next cycle, no mem_req, and Q unchanged.
- Aligned rd_start: at the edge, latch size, sign_ext and byte_off; mem_req=1, mem_we=0, mem_be=lane mask, busy=1; go to RD.
- Aligned wr_start: at the edge, mem_req=1 and mem_we=1; go to WR. mem_wdata and mem_be are set as follows and held constant while in WR:
  - byte: Q[7:0] replicated to every lane; mem_be = 1<<byte_off.
  - halfword: Q[15:0] replicated; mem_be = 2'b11<<byte_off.
  - full width: mem_wdata = Q; mem_be = all ones.
- Lane mask for reads follows the same rule as for writes.
- RD with mem_ack=1:
  - Q <= extracted lane(s) of mem_rdata, shifted to bit 0 and sign- or zero-extended to DATA_W.
  - done=1 for one cycle; mem_req=0, busy=0; go to IDLE.
  - Minimum latency: start edge to Q update is 2 edges when ack arrives in the first RD cycle.
- WR with mem_ack=1: done=1, mem_req=0, busy=0, Q unchanged; go to IDLE.
- Timeout:
  - Counter clears on entry to RD/WR and increments every cycle without ack.
  - If ack has not arrived in the TIMEOUT-th cycle of mem_req, then on that edge: err=1, mem_req=0, busy=0, go to IDLE, Q unchanged.
  - If ack arrives in that same cycle, the ack wins.
  - TIMEOUT=0: wait indefinitely.
- While busy, rd_start, wr_start and mdr_in are ignored (no queuing).
- mem_ack while in IDLE is ignored.
- done and err are never high in the same cycle.
- mem_we, mem_be and mem_wdata hold their last values after completion; the memory side ignores them when mem_req=0.

Test Plan:
- Reset then mdr_in with BusMuxOut=0x1234_5678 -> Q=0x1234_5678 next edge; busy=0, mem_req=0.
- Signed byte read, byte_off=3, ack in the first RD cycle, mem_rdata=0x80F0_1234 -> mem_be=4'b1000, Q=0xFFFF_FF80, done pulse; the same access unsigned -> Q=0x0000_0080.
- Halfword read, byte_off=2, unsigned, mem_rdata=0x80F0_1234, ack after 3 wait cycles -> mem_req high for 4 cycles, mem_be=4'b1100, Q=0x0000_80F0.
- Q=0x0000_00AB, byte write, byte_off=1 -> mem_we=1, mem_wdata=0xABAB_ABAB, mem_be=4'b0010; on ack, done and Q unchanged.
- Misaligned halfword read at byte_off=1 -> err next cycle, mem_req never asserted. Full-width read with no ack and TIMEOUT=16 -> err on the 16th req cycle, mem_req drops, Q unchanged.
- Reset asserted mid-RD -> mem_req and busy go to 0 asynchronously, Q=0; a later ack is ignored; rd_start together with mdr_in -> read performed, bus value discarded.
